// File: rtl/iter_muldiv.sv
// iter_muldiv: multi-cycle multiply/divide unit for the Execute stage.
// Handles MUL (low half), MULH (signed high half), DIV and REM (signed),
// one bit per clock: shift-add multiplier, restoring divider.
// Define MULDIV_DIV_EN to build the divide datapath; without it only the
// multiplier exists and DIV/REM return all ones after a short fixed latency.
module iter_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             divByZero_o
);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_REM  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } stateT;

  stateT                 state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic                  resNeg_q, resNeg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0]      mcand_q, mcand_d;
  logic                  done_q, done_d;
  logic [WIDTH-1:0]      result_q, result_d;
  logic                  divByZero_q, divByZero_d;

  // Operand magnitudes and signs; the most negative value keeps its bit
  // pattern, which read as unsigned is exactly its magnitude.
  logic                  aSign, bSign;
  logic [WIDTH-1:0]      aMag, bMag;

  assign aSign = a_i[WIDTH-1];
  assign bSign = b_i[WIDTH-1];
  assign aMag  = aSign ? (-a_i) : a_i;
  assign bMag  = bSign ? (-b_i) : b_i;

  // Multiplier step: the high half accumulates the multiplicand whenever
  // the multiplier bit at the bottom of the product register is set.
  logic [WIDTH-1:0]      mulAddend;
  logic [WIDTH:0]        mulSum;
  logic [2*WIDTH-1:0]    mulNext;
  logic [2*WIDTH-1:0]    prodSigned;

  assign mulAddend  = prod_q[0] ? mcand_q : '0;
  assign mulSum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mulAddend};
  assign mulNext    = {mulSum, prod_q[WIDTH-1:1]};
  assign prodSigned = resNeg_q ? (-prod_q) : prod_q;

`ifdef MULDIV_DIV_EN
  // Divider state: the low half of prod_q holds the dividend being shifted
  // out and the quotient being shifted in; mcand_q holds the divisor.
  logic [WIDTH-1:0]      rem_q, rem_d;
  logic                  special_q, special_d;
  logic [WIDTH:0]        divShift, divTrial;
  logic                  divBit;
  logic [WIDTH-1:0]      divRemNext, divQuoNext;
  logic [WIDTH-1:0]      quoSigned, remMag, remSigned;

  assign divShift   = {rem_q, prod_q[WIDTH-1]};
  assign divTrial   = divShift - {1'b0, mcand_q};
  assign divBit     = ~divTrial[WIDTH];
  assign divRemNext = divBit ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0];
  assign divQuoNext = {prod_q[WIDTH-2:0], divBit};
  assign quoSigned  = resNeg_q ? (-prod_q[WIDTH-1:0]) : prod_q[WIDTH-1:0];
  assign remMag     = special_q ? prod_q[WIDTH-1:0] : rem_q;
  assign remSigned  = resNeg_q ? (-remMag) : remMag;
`endif

  // Next-state logic for the control FSM and the iteration datapath.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    resNeg_d    = resNeg_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    done_d      = 1'b0;
    result_d    = result_q;
    divByZero_d = divByZero_q;
`ifdef MULDIV_DIV_EN
    rem_d       = rem_q;
    special_d   = special_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d  = op_i;
          cnt_d = CNT_W'(WIDTH);
          if (!op_i[1]) begin
            mcand_d  = aMag;
            prod_d   = {{WIDTH{1'b0}}, bMag};
            resNeg_d = aSign ^ bSign;
            state_d  = RUN;
          end else begin
`ifdef MULDIV_DIV_EN
            mcand_d   = bMag;
            prod_d    = {{WIDTH{1'b0}}, aMag};
            rem_d     = '0;
            resNeg_d  = (op_i == OP_REM) ? aSign : (aSign ^ bSign);
            special_d = (b_i == '0);
            state_d   = (b_i == '0) ? FIX : RUN;
`else
            state_d   = FIX;
`endif
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
`ifdef MULDIV_DIV_EN
        if (op_q[1]) begin
          rem_d  = divRemNext;
          prod_d = {prod_q[2*WIDTH-1:WIDTH], divQuoNext};
        end else begin
          prod_d = mulNext;
        end
`else
        prod_d = mulNext;
`endif
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        case (op_q)
          OP_MUL: begin
            result_d    = prodSigned[WIDTH-1:0];
            divByZero_d = 1'b0;
          end
          OP_MULH: begin
            result_d    = prodSigned[2*WIDTH-1:WIDTH];
            divByZero_d = 1'b0;
          end
`ifdef MULDIV_DIV_EN
          OP_DIV: begin
            result_d    = special_q ? '1 : quoSigned;
            divByZero_d = special_q;
          end
          OP_REM: begin
            result_d    = remSigned;
            divByZero_d = special_q;
          end
`else
          OP_DIV, OP_REM: begin
            result_d    = '1;
            divByZero_d = 1'b0;
          end
`endif
          default: begin
            result_d    = '0;
            divByZero_d = 1'b0;
          end
        endcase
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      op_q        <= OP_MUL;
      resNeg_q    <= 1'b0;
      cnt_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      done_q      <= 1'b0;
      result_q    <= '0;
      divByZero_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_q       <= '0;
      special_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      resNeg_q    <= resNeg_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      done_q      <= done_d;
      result_q    <= result_d;
      divByZero_q <= divByZero_d;
`ifdef MULDIV_DIV_EN
      rem_q       <= rem_d;
      special_q   <= special_d;
`endif
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign divByZero_o = divByZero_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Self-checking bench for iter_muldiv: expected results are queued when an
// operation is issued and compared when done pulses. Expectations follow
// MULDIV_DIV_EN so the bench matches whichever build it is compiled with.
module tb_iter_muldiv;

  localparam int W = 32;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         dbz;

  iter_muldiv #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .op_i        (op),
    .a_i         (a),
    .b_i         (b),
    .busy_o      (busy),
    .done_o      (done),
    .result_o    (result),
    .divByZero_o (dbz)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic         dbz;
    int           acceptEdge;
    int           lat;
  } expT;

  expT          sb[$];
  expT          monE;
  expT          stimA, stimB;
  int           checks = 0;
  int           fails = 0;
  int           cycleCount = 0;
  int           guard;
  logic [W-1:0] heldResult = '0;
  logic         prevDone = 1'b0;

  // Counts rising edges so latencies can be measured from acceptance.
  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model built on the simulator's own signed arithmetic.
  function automatic expT model(input string tag, input logic [1:0] o,
                                input logic [W-1:0] x, input logic [W-1:0] y);
    expT                   e;
    logic signed [2*W-1:0] p;
    logic signed [W-1:0]   sx, sy, q, r;
    sx = x;
    sy = y;
    p  = sx * sy;
    e.tag = tag;
    e.dbz = 1'b0;
    e.lat = W + 1;
    e.acceptEdge = 0;
    e.res = '0;
    case (o)
      2'b00: e.res = p[W-1:0];
      2'b01: e.res = p[2*W-1:W];
      default: begin
`ifdef MULDIV_DIV_EN
        if (y == '0) begin
          e.lat = 1;
          e.dbz = 1'b1;
          e.res = (o == 2'b10) ? '1 : x;
        end else if (x == MINV && y == '1) begin
          e.res = (o == 2'b10) ? MINV : '0;
        end else begin
          q = sx / sy;
          r = sx % sy;
          e.res = (o == 2'b10) ? q : r;
        end
`else
        e.lat = 1;
        e.res = '1;
`endif
      end
    endcase
    return e;
  endfunction

  // Issues one operation once the unit is idle and queues its expectation.
  task automatic applyStimulus(input string tag, input logic [1:0] o,
                               input logic [W-1:0] x, input logic [W-1:0] y);
    expT e;
    int  g;
    @(negedge clk);
    g = 0;
    while (busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    checkOutput({tag, "_idleBeforeStart"}, busy, 0);
    e = model(tag, o, x, y);
    e.acceptEdge = cycleCount + 1;
    sb.push_back(e);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_busyAfterAccept"}, busy, 1);
  endtask

  task automatic waitDrain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    checkOutput("drainTimeout", sb.size(), 0);
    sb.delete();
  endtask

  // Scoreboard side: compares every done pulse and checks result holding.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        checkOutput("doneRepeat", prevDone, 0);
        if (sb.size() == 0) begin
          checkOutput("spuriousDone", done, 0);
        end else begin
          monE = sb.pop_front();
          checkOutput({monE.tag, "_result"}, result, monE.res);
          checkOutput({monE.tag, "_dbz"}, dbz, monE.dbz);
          checkOutput({monE.tag, "_latency"}, cycleCount, monE.acceptEdge + monE.lat);
          checkOutput({monE.tag, "_busyInDone"}, busy, 0);
          heldResult = monE.res;
        end
      end else begin
        checkOutput("resultHeld", result, heldResult);
      end
    end
    prevDone = done;
  end

  initial begin
    #12;
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetResult", result, 0);
    checkOutput("resetDbz", dbz, 0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("mulNeg7x6", 2'b00, -7, 6);
    applyStimulus("mulhNeg7x6", 2'b01, -7, 6);
    applyStimulus("mulhMinxMin", 2'b01, 32'h8000_0000, 32'h8000_0000);
    applyStimulus("mulMinxNeg1", 2'b00, 32'h8000_0000, -1);
    applyStimulus("mulhMaxxMax", 2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    applyStimulus("divNeg20by3", 2'b10, -20, 3);
    applyStimulus("remNeg20by3", 2'b11, -20, 3);
    applyStimulus("div7byNeg3", 2'b10, 7, -3);
    applyStimulus("rem7byNeg3", 2'b11, 7, -3);
    applyStimulus("divMinByNeg1", 2'b10, 32'h8000_0000, -1);
    applyStimulus("remMinByNeg1", 2'b11, 32'h8000_0000, -1);
    applyStimulus("div5by0", 2'b10, 5, 0);
    applyStimulus("rem5by0", 2'b11, 5, 0);
    applyStimulus("remNeg9by0", 2'b11, -9, 0);
    waitDrain();

    // Start held high across two operations; operand changes while busy
    // must not disturb the first, and the second starts in the done cycle.
    @(negedge clk);
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    stimA = model("b2bFirst", 2'b00, 11, 13);
    stimA.acceptEdge = cycleCount + 1;
    sb.push_back(stimA);
    start = 1'b1;
    op = 2'b00;
    a = 11;
    b = 13;
    @(negedge clk);
    stimB = model("b2bSecond", 2'b01, -99, 32'h4000_0077);
    stimB.acceptEdge = stimA.acceptEdge + W + 2;
    sb.push_back(stimB);
    op = 2'b01;
    a = -99;
    b = 32'h4000_0077;
    guard = 0;
    while (cycleCount < stimB.acceptEdge && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    waitDrain();

    // Start pulses while busy are ignored.
    applyStimulus("pulseBase", 2'b01, 32'h1234_5678, 32'hFEDC_BA98);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b1;
      op = 2'(i % 4);
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      start = 1'b0;
    end
    waitDrain();

    for (int i = 0; i < 16; i++) begin
      applyStimulus($sformatf("rand%0d", i), 2'($urandom_range(0, 3)),
                    $urandom, (i % 5 == 0) ? 32'h0 : $urandom);
    end
    waitDrain();

    // Asynchronous reset in the middle of an operation aborts it.
    applyStimulus("preAbort", 2'b00, 3, 5);
    waitDrain();
    applyStimulus("aborted", 2'b00, 1234, 5678);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortResult", result, 0);
    checkOutput("abortDbz", dbz, 0);
    sb.delete();
    heldResult = '0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("afterResetMul", 2'b00, -3, 5);
    applyStimulus("afterResetDiv", 2'b10, 100, 7);
    waitDrain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
